reservation_station: RTL and testbench

//  ALU-side reservation station: buffers issued non-memory ops until both source operands are known.

---
 rtl/reservation_station_pkg.sv | 25 ++
 rtl/reservation_station_if.sv | 60 ++++++
 rtl/reservation_station_rs_prio_enc.sv | 23 ++
 rtl/reservation_station.sv | 136 +++++++++++++
 tb/tb_reservation_station.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/reservation_station_pkg.sv
// Shared op encodings and data types for the ALU reservation station slice.
// Replaces the old defines header; consumers import reservation_station_pkg::*.
package reservation_station_pkg;

    localparam int unsigned RS_SIZE_DEF   = 16;
    localparam int unsigned RS_WIDTH_DEF  = 4;
    localparam int unsigned ROB_WIDTH_DEF = 4;

    typedef enum logic [5:0] {
        OPENUM_NOP, OPENUM_LUI, OPENUM_AUIPC, OPENUM_JAL, OPENUM_JALR,
        OPENUM_BEQ, OPENUM_BNE, OPENUM_BLT, OPENUM_BGE, OPENUM_BLTU, OPENUM_BGEU,
        OPENUM_ADDI, OPENUM_SLTI, OPENUM_SLTIU, OPENUM_XORI, OPENUM_ORI, OPENUM_ANDI,
        OPENUM_SLLI, OPENUM_SRLI, OPENUM_SRAI,
        OPENUM_ADD, OPENUM_SUB, OPENUM_SLL, OPENUM_SLT, OPENUM_SLTU,
        OPENUM_XOR, OPENUM_SRL, OPENUM_SRA, OPENUM_OR, OPENUM_AND
    } openum_t;

    typedef enum logic [2:0] {
        OP_ARITH, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC
    } op_type_t;

    typedef logic [31:0] data_t;
    typedef logic [31:0] addr_t;

endpackage

// File: rtl/reservation_station_if.sv
// Issue, result-broadcast and ALU-dispatch bundle around the reservation station.
// master = issue/broadcast side, slave = reservation station.
interface reservation_station_if #(
    parameter int unsigned ROB_WIDTH = 4
) ();
    import reservation_station_pkg::*;

    logic                 issue_valid;
    openum_t              issue_op;
    op_type_t             issue_opType;
    data_t                issue_Vj;
    data_t                issue_Vk;
    logic                 issue_Qj_valid;
    logic                 issue_Qk_valid;
    logic [ROB_WIDTH-1:0] issue_Qj;
    logic [ROB_WIDTH-1:0] issue_Qk;
    logic [ROB_WIDTH-1:0] issue_rob_index;
    addr_t                issue_PC;
    data_t                issue_imm;

    logic                 alu_ready;
    data_t                alu_result;
    logic [ROB_WIDTH-1:0] alu_rob_index;
    logic                 lsb_ready;
    data_t                lsb_result;
    logic [ROB_WIDTH-1:0] lsb_rob_index;

    logic                 rs_full;
    logic                 rs_to_alu_ready;
    openum_t              rs_to_alu_op;
    op_type_t             rs_to_alu_opType;
    data_t                rs_to_alu_rs1;
    data_t                rs_to_alu_rs2;
    logic [ROB_WIDTH-1:0] rs_to_alu_rob_index;
    addr_t                rs_to_alu_PC;
    data_t                rs_to_alu_imm;

    modport master (
        output issue_valid, issue_op, issue_opType, issue_Vj, issue_Vk,
               issue_Qj_valid, issue_Qk_valid, issue_Qj, issue_Qk,
               issue_rob_index, issue_PC, issue_imm,
               alu_ready, alu_result, alu_rob_index,
               lsb_ready, lsb_result, lsb_rob_index,
        input  rs_full, rs_to_alu_ready, rs_to_alu_op, rs_to_alu_opType,
               rs_to_alu_rs1, rs_to_alu_rs2, rs_to_alu_rob_index,
               rs_to_alu_PC, rs_to_alu_imm
    );

    modport slave (
        input  issue_valid, issue_op, issue_opType, issue_Vj, issue_Vk,
               issue_Qj_valid, issue_Qk_valid, issue_Qj, issue_Qk,
               issue_rob_index, issue_PC, issue_imm,
               alu_ready, alu_result, alu_rob_index,
               lsb_ready, lsb_result, lsb_rob_index,
        output rs_full, rs_to_alu_ready, rs_to_alu_op, rs_to_alu_opType,
               rs_to_alu_rs1, rs_to_alu_rs2, rs_to_alu_rob_index,
               rs_to_alu_PC, rs_to_alu_imm
    );

endinterface

// File: rtl/reservation_station_rs_prio_enc.sv
// Lowest-index priority encoder: reports whether any bit is set and the index of the lowest one.
module rs_prio_enc #(
    parameter int unsigned N = 16,
    parameter int unsigned W = 4
) (
    input  logic [N-1:0] vec,
    output logic         found,
    output logic [W-1:0] idx
);

    // Scan downwards so the last assignment wins with the lowest set index.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = N; i > 0; i--) begin
            if (vec[i-1]) begin
                found = 1'b1;
                idx   = W'(i - 1);
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// ALU reservation station: holds issued ops until both operands arrive via ALU/LSB broadcast,
// then dispatches the lowest-index ready entry to the ALU as a registered one-cycle pulse.
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int unsigned RS_SIZE   = RS_SIZE_DEF,
    parameter int unsigned RS_WIDTH  = RS_WIDTH_DEF,
    parameter int unsigned ROB_WIDTH = ROB_WIDTH_DEF
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic rdy_in,
    input  logic clr_in,
    reservation_station_if.slave bus
);

    logic [RS_SIZE-1:0]   busy;
    logic [RS_SIZE-1:0]   qj_valid;
    logic [RS_SIZE-1:0]   qk_valid;
    openum_t              op_q     [RS_SIZE];
    op_type_t             optype_q [RS_SIZE];
    data_t                vj       [RS_SIZE];
    data_t                vk       [RS_SIZE];
    logic [ROB_WIDTH-1:0] qj       [RS_SIZE];
    logic [ROB_WIDTH-1:0] qk       [RS_SIZE];
    logic [ROB_WIDTH-1:0] rob_q    [RS_SIZE];
    addr_t                pc_q     [RS_SIZE];
    data_t                imm_q    [RS_SIZE];

    logic                free_found, disp_found;
    logic [RS_WIDTH-1:0] free_idx, disp_idx;
    data_t               new_vj, new_vk;
    logic                new_qjv, new_qkv;

    rs_prio_enc #(.N(RS_SIZE), .W(RS_WIDTH)) u_free_enc (
        .vec   (~busy),
        .found (free_found),
        .idx   (free_idx)
    );

    rs_prio_enc #(.N(RS_SIZE), .W(RS_WIDTH)) u_disp_enc (
        .vec   (busy & ~qj_valid & ~qk_valid),
        .found (disp_found),
        .idx   (disp_idx)
    );

    assign bus.rs_full = ~free_found;

    // Same-cycle broadcast bypass for the entry being written; ALU wins over LSB.
    always_comb begin
        new_vj  = bus.issue_Vj;
        new_qjv = bus.issue_Qj_valid;
        new_vk  = bus.issue_Vk;
        new_qkv = bus.issue_Qk_valid;
        if (bus.issue_Qj_valid && bus.alu_ready && bus.issue_Qj == bus.alu_rob_index) begin
            new_vj  = bus.alu_result;
            new_qjv = 1'b0;
        end else if (bus.issue_Qj_valid && bus.lsb_ready && bus.issue_Qj == bus.lsb_rob_index) begin
            new_vj  = bus.lsb_result;
            new_qjv = 1'b0;
        end
        if (bus.issue_Qk_valid && bus.alu_ready && bus.issue_Qk == bus.alu_rob_index) begin
            new_vk  = bus.alu_result;
            new_qkv = 1'b0;
        end else if (bus.issue_Qk_valid && bus.lsb_ready && bus.issue_Qk == bus.lsb_rob_index) begin
            new_vk  = bus.lsb_result;
            new_qkv = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || clr_in) begin
            busy                    <= '0;
            bus.rs_to_alu_ready     <= 1'b0;
            bus.rs_to_alu_op        <= OPENUM_NOP;
            bus.rs_to_alu_opType    <= OP_ARITH;
            bus.rs_to_alu_rs1       <= '0;
            bus.rs_to_alu_rs2       <= '0;
            bus.rs_to_alu_rob_index <= '0;
            bus.rs_to_alu_PC        <= '0;
            bus.rs_to_alu_imm       <= '0;
        end else if (rdy_in) begin
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                if (busy[i] && qj_valid[i]) begin
                    if (bus.alu_ready && qj[i] == bus.alu_rob_index) begin
                        vj[i]       <= bus.alu_result;
                        qj_valid[i] <= 1'b0;
                    end else if (bus.lsb_ready && qj[i] == bus.lsb_rob_index) begin
                        vj[i]       <= bus.lsb_result;
                        qj_valid[i] <= 1'b0;
                    end
                end
                if (busy[i] && qk_valid[i]) begin
                    if (bus.alu_ready && qk[i] == bus.alu_rob_index) begin
                        vk[i]       <= bus.alu_result;
                        qk_valid[i] <= 1'b0;
                    end else if (bus.lsb_ready && qk[i] == bus.lsb_rob_index) begin
                        vk[i]       <= bus.lsb_result;
                        qk_valid[i] <= 1'b0;
                    end
                end
            end

            // Dispatch selects from pre-edge state, so a same-edge wakeup waits one cycle.
            if (disp_found) begin
                bus.rs_to_alu_ready     <= 1'b1;
                bus.rs_to_alu_op        <= op_q[disp_idx];
                bus.rs_to_alu_opType    <= optype_q[disp_idx];
                bus.rs_to_alu_rs1       <= vj[disp_idx];
                bus.rs_to_alu_rs2       <= vk[disp_idx];
                bus.rs_to_alu_rob_index <= rob_q[disp_idx];
                bus.rs_to_alu_PC        <= pc_q[disp_idx];
                bus.rs_to_alu_imm       <= imm_q[disp_idx];
                busy[disp_idx]          <= 1'b0;
            end else begin
                bus.rs_to_alu_ready <= 1'b0;
            end

            if (bus.issue_valid && free_found) begin
                busy[free_idx]     <= 1'b1;
                op_q[free_idx]     <= bus.issue_op;
                optype_q[free_idx] <= bus.issue_opType;
                vj[free_idx]       <= new_vj;
                vk[free_idx]       <= new_vk;
                qj_valid[free_idx] <= new_qjv;
                qk_valid[free_idx] <= new_qkv;
                qj[free_idx]       <= bus.issue_Qj;
                qk[free_idx]       <= bus.issue_Qk;
                rob_q[free_idx]    <= bus.issue_rob_index;
                pc_q[free_idx]     <= bus.issue_PC;
                imm_q[free_idx]    <= bus.issue_imm;
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Scoreboard bench for reservation_station: stimulus pushes expected dispatches with their
// expected cycle, a negedge monitor pops and compares whenever rs_to_alu_ready is seen.
module tb_reservation_station;
    import reservation_station_pkg::*;

    logic clk_in = 1'b0;
    logic rst_in, rdy_in, clr_in;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;

    typedef struct {
        int          cyc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [3:0]  rob;
        logic [31:0] pc;
        logic [31:0] imm;
        openum_t     op;
    } exp_t;

    exp_t sb[$];

    reservation_station_if #(.ROB_WIDTH(4)) bus ();

    reservation_station #(.RS_SIZE(16), .RS_WIDTH(4), .ROB_WIDTH(4)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .clr_in (clr_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic issue(input openum_t op, input logic [31:0] vj, input logic [31:0] vk,
                         input logic qjv, input logic [3:0] qj, input logic qkv, input logic [3:0] qk,
                         input logic [3:0] rob, input logic [31:0] pc, input logic [31:0] imm);
        bus.issue_valid     = 1'b1;
        bus.issue_op        = op;
        bus.issue_opType    = OP_ARITH;
        bus.issue_Vj        = vj;
        bus.issue_Vk        = vk;
        bus.issue_Qj_valid  = qjv;
        bus.issue_Qj        = qj;
        bus.issue_Qk_valid  = qkv;
        bus.issue_Qk        = qk;
        bus.issue_rob_index = rob;
        bus.issue_PC        = pc;
        bus.issue_imm       = imm;
    endtask

    task automatic expect_disp(input int c, input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic [3:0] rob, input logic [31:0] pc, input logic [31:0] imm,
                               input openum_t op);
        exp_t e;
        e.cyc = c; e.rs1 = rs1; e.rs2 = rs2; e.rob = rob; e.pc = pc; e.imm = imm; e.op = op;
        sb.push_back(e);
    endtask

    // Monitor: every observed dispatch must match the head of the scoreboard at its expected cycle.
    always @(negedge clk_in) begin
        exp_t e;
        if (mon_en) begin
            if (bus.rs_to_alu_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_dispatch: got rob 0x%0h rs1 0x%0h expected no dispatch (cycle %0d)",
                             bus.rs_to_alu_rob_index, bus.rs_to_alu_rs1, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("disp_cycle", cyc, e.cyc);
                    chk("disp_rs1", bus.rs_to_alu_rs1, e.rs1);
                    chk("disp_rs2", bus.rs_to_alu_rs2, e.rs2);
                    chk("disp_rob", {28'd0, bus.rs_to_alu_rob_index}, {28'd0, e.rob});
                    chk("disp_pc", bus.rs_to_alu_PC, e.pc);
                    chk("disp_imm", bus.rs_to_alu_imm, e.imm);
                    chk("disp_op", {26'd0, bus.rs_to_alu_op}, {26'd0, e.op});
                end
            end else if (sb.size() != 0 && cyc >= sb[0].cyc) begin
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_dispatch: got none expected rob 0x%0h at cycle %0d (now %0d)",
                         e.rob, e.cyc, cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    int c;

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; clr_in = 1'b0;
        bus.issue_valid = 1'b0; bus.issue_op = OPENUM_NOP; bus.issue_opType = OP_ARITH;
        bus.issue_Vj = '0; bus.issue_Vk = '0; bus.issue_Qj_valid = 1'b0; bus.issue_Qk_valid = 1'b0;
        bus.issue_Qj = '0; bus.issue_Qk = '0; bus.issue_rob_index = '0; bus.issue_PC = '0; bus.issue_imm = '0;
        bus.alu_ready = 1'b0; bus.alu_result = '0; bus.alu_rob_index = '0;
        bus.lsb_ready = 1'b0; bus.lsb_result = '0; bus.lsb_rob_index = '0;
        repeat (3) tick();
        rst_in = 1'b0;
        chk("reset_full", {31'd0, bus.rs_full}, 32'd0);
        chk("reset_ready", {31'd0, bus.rs_to_alu_ready}, 32'd0);
        chk("reset_rs1", bus.rs_to_alu_rs1, 32'd0);
        chk("reset_rob", {28'd0, bus.rs_to_alu_rob_index}, 32'd0);
        mon_en = 1'b1;

        // Both operands known: dispatch one edge after the issue edge.
        c = cyc;
        issue(OPENUM_ADD, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3, 32'h100, 32'd0);
        expect_disp(c + 2, 32'd5, 32'd7, 4'd3, 32'h100, 32'd0, OPENUM_ADD);
        tick(); bus.issue_valid = 1'b0;
        repeat (3) tick();

        // Qj pending, ALU broadcast two cycles later.
        c = cyc;
        issue(OPENUM_ADDI, 32'hDEAD, 32'd0, 1'b1, 4'd2, 1'b0, 4'd0, 4'd6, 32'h104, 32'd4);
        expect_disp(c + 4, 32'h10, 32'd0, 4'd6, 32'h104, 32'd4, OPENUM_ADDI);
        tick(); bus.issue_valid = 1'b0;
        tick();
        bus.alu_ready = 1'b1; bus.alu_rob_index = 4'd2; bus.alu_result = 32'h10;
        tick(); bus.alu_ready = 1'b0;
        repeat (3) tick();

        // Issue-cycle LSB bypass on Qk.
        c = cyc;
        issue(OPENUM_SUB, 32'd9, 32'hBEEF, 1'b0, 4'd0, 1'b1, 4'd5, 4'd8, 32'h108, 32'd0);
        bus.lsb_ready = 1'b1; bus.lsb_rob_index = 4'd5; bus.lsb_result = 32'hAB;
        expect_disp(c + 2, 32'd9, 32'hAB, 4'd8, 32'h108, 32'd0, OPENUM_SUB);
        tick(); bus.issue_valid = 1'b0; bus.lsb_ready = 1'b0;
        repeat (3) tick();

        // Fill all 16 entries, each waiting on ROB tag equal to its entry index.
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("full_at_15", {31'd0, bus.rs_full}, 32'd0);
            issue(OPENUM_ADD, 32'hDEAD, 32'h100 + i, 1'b1, 4'(i), 1'b0, 4'd0, 4'(i), 32'h1000 + 4 * i, 32'(i));
            tick();
        end
        chk("full_at_16", {31'd0, bus.rs_full}, 32'd1);
        issue(OPENUM_OR, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd14, 32'h3000, 32'd0);
        tick(); bus.issue_valid = 1'b0;
        chk("full_after_17th", {31'd0, bus.rs_full}, 32'd1);

        // Wake entry 7; its slot frees on dispatch and is reused.
        c = cyc;
        bus.alu_ready = 1'b1; bus.alu_rob_index = 4'd7; bus.alu_result = 32'h700;
        expect_disp(c + 2, 32'h700, 32'h107, 4'd7, 32'h101C, 32'd7, OPENUM_ADD);
        tick(); bus.alu_ready = 1'b0;
        tick();
        chk("full_after_free", {31'd0, bus.rs_full}, 32'd0);
        c = cyc;
        issue(OPENUM_XOR, 32'h11, 32'h22, 1'b0, 4'd0, 1'b0, 4'd0, 4'd13, 32'h2004, 32'd0);
        expect_disp(c + 2, 32'h11, 32'h22, 4'd13, 32'h2004, 32'd0, OPENUM_XOR);
        tick(); bus.issue_valid = 1'b0;
        chk("full_after_reuse", {31'd0, bus.rs_full}, 32'd1);
        repeat (3) tick();

        // Entries 1 and 4 woken on the same edge: lower index goes first.
        c = cyc;
        bus.alu_ready = 1'b1; bus.alu_rob_index = 4'd4; bus.alu_result = 32'h444;
        bus.lsb_ready = 1'b1; bus.lsb_rob_index = 4'd1; bus.lsb_result = 32'h111;
        expect_disp(c + 2, 32'h111, 32'h101, 4'd1, 32'h1004, 32'd1, OPENUM_ADD);
        expect_disp(c + 3, 32'h444, 32'h104, 4'd4, 32'h1010, 32'd4, OPENUM_ADD);
        tick(); bus.alu_ready = 1'b0; bus.lsb_ready = 1'b0;
        repeat (4) tick();

        // Flush: empty, dispatch one op, fill 6 pending, flush with a concurrent ready issue.
        clr_in = 1'b1;
        tick(); clr_in = 1'b0;
        chk("clr_empty_full", {31'd0, bus.rs_full}, 32'd0);
        c = cyc;
        issue(OPENUM_AND, 32'h55, 32'h66, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9, 32'h2100, 32'd0);
        expect_disp(c + 2, 32'h55, 32'h66, 4'd9, 32'h2100, 32'd0, OPENUM_AND);
        tick();
        for (int i = 0; i < 6; i++) begin
            issue(OPENUM_ADD, 32'd0, 32'd0, 1'b1, 4'(8 + i), 1'b0, 4'd0, 4'(8 + i), 32'h2200, 32'd0);
            tick();
        end
        issue(OPENUM_ADD, 32'h77, 32'h78, 1'b0, 4'd0, 1'b0, 4'd0, 4'd15, 32'h2300, 32'd0);
        clr_in = 1'b1;
        tick(); clr_in = 1'b0; bus.issue_valid = 1'b0;
        chk("clr_full", {31'd0, bus.rs_full}, 32'd0);
        chk("clr_ready", {31'd0, bus.rs_to_alu_ready}, 32'd0);
        chk("clr_rs1", bus.rs_to_alu_rs1, 32'd0);
        chk("clr_rob", {28'd0, bus.rs_to_alu_rob_index}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            bus.alu_ready = 1'b1; bus.alu_rob_index = 4'(8 + i); bus.alu_result = 32'h9;
            tick();
        end
        bus.alu_ready = 1'b0;
        repeat (3) tick();

        // rdy_in low freezes state, including the held dispatch pulse.
        c = cyc;
        issue(OPENUM_SLT, 32'h99, 32'h88, 1'b0, 4'd0, 1'b0, 4'd0, 4'd10, 32'h2400, 32'd0);
        expect_disp(c + 2, 32'h99, 32'h88, 4'd10, 32'h2400, 32'd0, OPENUM_SLT);
        tick(); bus.issue_valid = 1'b0;
        tick();
        rdy_in = 1'b0;
        @(negedge clk_in); #1;
        mon_en = 1'b0;
        issue(OPENUM_OR, 32'h1, 32'h2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd11, 32'h2500, 32'd0);
        repeat (3) tick();
        chk("frz_ready", {31'd0, bus.rs_to_alu_ready}, 32'd1);
        chk("frz_rs1", bus.rs_to_alu_rs1, 32'h99);
        chk("frz_rob", {28'd0, bus.rs_to_alu_rob_index}, 32'd10);
        chk("frz_full", {31'd0, bus.rs_full}, 32'd0);
        bus.issue_valid = 1'b0;
        rdy_in = 1'b1;
        tick();
        mon_en = 1'b1;
        chk("unfrz_ready", {31'd0, bus.rs_to_alu_ready}, 32'd0);
        chk("unfrz_hold_rs1", bus.rs_to_alu_rs1, 32'h99);
        repeat (4) tick();

        chk("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
